// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor speed path (prescaler finder and period meter).
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALIB,
    SYNC,
    MEASURE,
    STALLED
  } meter_state_t;

  // Periods shorter than 1/8 of the counter range are considered too coarse.
  function automatic int recal_low_default(input int period_width);
    return 1 << (period_width - 3);
  endfunction

endpackage

// File: rtl/presc_tick_gen.sv
// Prescaled tick generator: one tick every i_presc+1 enabled clocks.
module presc_tick_gen #(
  parameter int K_PRESCWIDTH = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_en,
  input  logic [K_PRESCWIDTH-1:0] i_presc,
  output logic                    o_tick
);

  logic [K_PRESCWIDTH-1:0] div_reg;

  assign o_tick = i_en && (div_reg == i_presc);

  // Clear wins over counting so a restart always begins a full tick period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_reg <= '0;
    end else if (i_clear) begin
      div_reg <= '0;
    end else if (i_en) begin
      div_reg <= o_tick ? '0 : div_reg + K_PRESCWIDTH'(1);
    end
  end

endmodule

// File: rtl/hall_period_meter.sv
// Measures hall edge-to-edge period in prescaled ticks; requests recalibration
// from the prescaler finder on stall or insufficient resolution.
module hall_period_meter
  import motor_pkg::*;
#(
  parameter int K_PERIODWIDTH = 13,
  parameter int K_PRESCWIDTH  = 7,
  parameter int K_RECAL_LOW   = recal_low_default(K_PERIODWIDTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_reference_event,
  input  logic [K_PRESCWIDTH-1:0]  i_prescaler,
  input  logic                     i_prescaler_valid,
  output logic                     o_recal_req,
  output logic [K_PERIODWIDTH-1:0] o_period,
  output logic [K_PRESCWIDTH-1:0]  o_period_prescaler,
  output logic                     o_period_valid,
  output logic                     o_stalled
);

  localparam logic [K_PERIODWIDTH-1:0] RECAL_LOW = K_PERIODWIDTH'(K_RECAL_LOW);

  meter_state_t             state_reg, state_next;
  logic [K_PRESCWIDTH-1:0]  presc_reg, presc_next;
  logic [K_PERIODWIDTH-1:0] cnt_reg, cnt_next;
  logic [K_PERIODWIDTH-1:0] period_reg, period_next;
  logic [K_PRESCWIDTH-1:0]  period_presc_reg, period_presc_next;
  logic                     valid_reg, valid_next;
  logic                     recal_reg, recal_next;
  logic                     stalled_reg, stalled_next;

  logic                     tick;
  logic                     tick_en;
  logic                     div_clear;
  logic [K_PERIODWIDTH:0]   cnt_sum;
  logic [K_PERIODWIDTH-1:0] captured;

  assign tick_en = (state_reg == MEASURE);

  presc_tick_gen #(
    .K_PRESCWIDTH(K_PRESCWIDTH)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(div_clear),
    .i_en   (tick_en),
    .i_presc(presc_reg),
    .o_tick (tick)
  );

  // A tick landing on the event edge belongs to the period just ending.
  assign cnt_sum  = {1'b0, cnt_reg} + (K_PERIODWIDTH + 1)'(tick);
  assign captured = cnt_sum[K_PERIODWIDTH] ? '1 : cnt_sum[K_PERIODWIDTH-1:0];

  always_comb begin
    state_next        = state_reg;
    presc_next        = presc_reg;
    cnt_next          = cnt_reg;
    period_next       = period_reg;
    period_presc_next = period_presc_reg;
    valid_next        = 1'b0;
    recal_next        = 1'b0;
    stalled_next      = stalled_reg;
    div_clear         = 1'b0;

    if (!i_enable) begin
      state_next   = IDLE;
      stalled_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = CALIB;
          recal_next = 1'b1;
        end
        CALIB: begin
          if (i_prescaler_valid) begin
            presc_next = i_prescaler;
            state_next = SYNC;
          end
        end
        SYNC: begin
          if (i_reference_event) begin
            cnt_next   = '0;
            div_clear  = 1'b1;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (i_reference_event) begin
            period_next       = captured;
            period_presc_next = presc_reg;
            valid_next        = 1'b1;
            cnt_next          = '0;
            div_clear         = 1'b1;
            if (captured < RECAL_LOW) begin
              recal_next = 1'b1;
              state_next = CALIB;
            end
          end else if (tick) begin
            if (&cnt_reg) begin
              stalled_next = 1'b1;
              state_next   = STALLED;
            end else begin
              cnt_next = cnt_reg + K_PERIODWIDTH'(1);
            end
          end
        end
        STALLED: begin
          if (i_reference_event) begin
            stalled_next = 1'b0;
            recal_next   = 1'b1;
            state_next   = CALIB;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg        <= IDLE;
      presc_reg        <= '0;
      cnt_reg          <= '0;
      period_reg       <= '0;
      period_presc_reg <= '0;
      valid_reg        <= 1'b0;
      recal_reg        <= 1'b0;
      stalled_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      presc_reg        <= presc_next;
      cnt_reg          <= cnt_next;
      period_reg       <= period_next;
      period_presc_reg <= period_presc_next;
      valid_reg        <= valid_next;
      recal_reg        <= recal_next;
      stalled_reg      <= stalled_next;
    end
  end

  assign o_recal_req        = recal_reg;
  assign o_period           = period_reg;
  assign o_period_prescaler = period_presc_reg;
  assign o_period_valid     = valid_reg;
  assign o_stalled          = stalled_reg;

endmodule
